// File: rtl/rx_word_align_ctrl.sv
// rx_word_align_ctrl: pulls serial bits from the FIFO read port, hunts for the
// K28.5 comma to fix the 10-bit word boundary, emits aligned symbols and
// tracks link quality (ALIGN -> LOCKED on repeated commas, back to HUNT on
// accumulated code errors).
module rx_word_align_ctrl #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_ERRS   = 4,
  parameter int GOOD_RUN    = 16
) (
  input  logic                               i_Rclk,
  input  logic                               i_Rrst_n,
  input  logic                               i_Enable,
  input  logic                               i_empty,
  output logic                               o_R_en,
  input  logic                               i_FIFO_Out,
  output logic [9:0]                         o_Sym,
  output logic                               o_Sym_Valid,
  output logic                               o_Is_Comma,
  output logic                               o_Code_Err,
  output logic                               o_Locked,
  output logic [1:0]                         o_State,
  output logic [$clog2(LOSS_ERRS+1)-1:0]     o_Err_Cnt
);

  localparam int EW = $clog2(LOSS_ERRS+1);
  localparam int CW = $clog2(LOCK_COMMAS+1);
  localparam int GW = $clog2(GOOD_RUN+1);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]    state;
  logic          bit_vld;
  logic [9:0]    win;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] comma_cnt;
  logic [EW-1:0] err_cnt;
  logic [GW-1:0] good_run;
  logic          pend_off;

  logic [9:0]    win_nx;
  logic          is_comma;
  logic [3:0]    ones;
  logic          ones_err;
  logic          boundary;
  logic          sym_err;

  assign o_R_en   = i_Enable & ~i_empty;
  // Window as it will look once the incoming bit is shifted in; all
  // decisions are made on this so the symbol is emitted at the shift edge.
  assign win_nx   = {win[8:0], i_FIFO_Out};
  assign is_comma = (win_nx == 10'b0011111010) || (win_nx == 10'b1100000101);
  assign ones_err = (ones < 4'd4) || (ones > 4'd6);
  assign boundary = (bit_cnt == 4'd9);
  // A pending off-boundary comma and a disparity error collapse into one error.
  assign sym_err  = ones_err | pend_off;

  assign o_State   = state;
  assign o_Locked  = (state == ST_LOCKED);
  assign o_Err_Cnt = err_cnt;

  // Ones count of the candidate symbol for the 4..6 balance check.
  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 10; i++) ones = ones + {3'd0, win_nx[i]};
  end

  // Bit capture, boundary tracking, sync state machine and symbol outputs.
  always_ff @(posedge i_Rclk or negedge i_Rrst_n) begin
    if (!i_Rrst_n) begin
      state       <= ST_HUNT;
      bit_vld     <= 1'b0;
      win         <= '0;
      bit_cnt     <= '0;
      comma_cnt   <= '0;
      err_cnt     <= '0;
      good_run    <= '0;
      pend_off    <= 1'b0;
      o_Sym       <= '0;
      o_Sym_Valid <= 1'b0;
      o_Is_Comma  <= 1'b0;
      o_Code_Err  <= 1'b0;
    end else if (!i_Enable) begin
      // Idle: drop any partial symbol and restart the hunt from scratch.
      state       <= ST_HUNT;
      bit_vld     <= 1'b0;
      win         <= '0;
      bit_cnt     <= '0;
      comma_cnt   <= '0;
      err_cnt     <= '0;
      good_run    <= '0;
      pend_off    <= 1'b0;
      o_Sym_Valid <= 1'b0;
    end else begin
      bit_vld     <= o_R_en;
      o_Sym_Valid <= 1'b0;
      if (bit_vld) begin
        win     <= win_nx;
        bit_cnt <= boundary ? 4'd0 : bit_cnt + 4'd1;
        case (state)
          ST_HUNT: begin
            if (is_comma) begin
              o_Sym       <= win_nx;
              o_Sym_Valid <= 1'b1;
              o_Is_Comma  <= 1'b1;
              o_Code_Err  <= 1'b0;
              bit_cnt     <= 4'd0;
              comma_cnt   <= CW'(1);
              err_cnt     <= '0;
              good_run    <= '0;
              pend_off    <= 1'b0;
              state       <= (LOCK_COMMAS <= 1) ? ST_LOCKED : ST_ALIGN;
            end
          end
          ST_ALIGN: begin
            if (boundary) begin
              o_Sym       <= win_nx;
              o_Sym_Valid <= 1'b1;
              o_Is_Comma  <= is_comma;
              o_Code_Err  <= ones_err;
              if (ones_err) begin
                state     <= ST_HUNT;
                comma_cnt <= '0;
              end else if (is_comma) begin
                if (int'(comma_cnt) < LOCK_COMMAS) comma_cnt <= comma_cnt + CW'(1);
                if (int'(comma_cnt) + 1 >= LOCK_COMMAS) begin
                  state    <= ST_LOCKED;
                  err_cnt  <= '0;
                  good_run <= '0;
                  pend_off <= 1'b0;
                end
              end
            end
          end
          ST_LOCKED: begin
            if (boundary) begin
              o_Sym       <= win_nx;
              o_Sym_Valid <= 1'b1;
              o_Is_Comma  <= is_comma;
              o_Code_Err  <= sym_err;
              pend_off    <= 1'b0;
              if (sym_err) begin
                good_run <= '0;
                if (int'(err_cnt) + 1 >= LOSS_ERRS) begin
                  state     <= ST_HUNT;
                  err_cnt   <= '0;
                  comma_cnt <= '0;
                end else begin
                  err_cnt <= err_cnt + EW'(1);
                end
              end else if (int'(good_run) + 1 >= GOOD_RUN) begin
                good_run <= '0;
                if (err_cnt != '0) err_cnt <= err_cnt - EW'(1);
              end else begin
                good_run <= good_run + GW'(1);
              end
            end else if (is_comma) begin
              // Comma at the wrong phase: charge it to the symbol in progress.
              pend_off <= 1'b1;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_word_align_ctrl.sv
// Bench for rx_word_align_ctrl: FIFO-like bit source, symbol-level reference
// model checked every cycle, a table of expected strobes for the lock/loss/
// recovery sequences, hand sequences for reset, stall and enable drop, then
// randomized traffic.
module tb_rx_word_align_ctrl;
  localparam int LOCK_COMMAS = 3;
  localparam int LOSS_ERRS   = 4;
  localparam int GOOD_RUN    = 16;
  localparam int EW = $clog2(LOSS_ERRS+1);

  logic clk, rst_n, i_Enable, i_empty, i_FIFO_Out;
  logic o_R_en, o_Sym_Valid, o_Is_Comma, o_Code_Err, o_Locked;
  logic [9:0] o_Sym;
  logic [1:0] o_State;
  logic [EW-1:0] o_Err_Cnt;

  rx_word_align_ctrl #(.LOCK_COMMAS(LOCK_COMMAS), .LOSS_ERRS(LOSS_ERRS), .GOOD_RUN(GOOD_RUN)) dut (
    .i_Rclk(clk), .i_Rrst_n(rst_n), .i_Enable(i_Enable), .i_empty(i_empty),
    .o_R_en(o_R_en), .i_FIFO_Out(i_FIFO_Out), .o_Sym(o_Sym), .o_Sym_Valid(o_Sym_Valid),
    .o_Is_Comma(o_Is_Comma), .o_Code_Err(o_Code_Err), .o_Locked(o_Locked),
    .o_State(o_State), .o_Err_Cnt(o_Err_Cnt));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (symbol framing by bit index) -------------
  int m_st, m_n, m_align, m_cc, m_err, m_good;
  bit m_pend;
  int m_w;
  bit e_vld, e_comma, e_err;
  int e_sym;

  function automatic void m_clear();
    m_st = 0; m_n = 0; m_align = 0; m_cc = 0; m_err = 0; m_good = 0;
    m_pend = 0; m_w = 0; e_vld = 0;
  endfunction

  function automatic void m_emit(int s, bit c, bit e);
    e_vld = 1; e_sym = s; e_comma = c; e_err = e;
  endfunction

  function automatic void m_bit(bit b);
    bit cm, oe, err;
    int ones;
    m_n++;
    m_w = ((m_w * 2) + b) % 1024;
    cm = (m_w == 'h0FA) || (m_w == 'h305);
    ones = $countones(m_w[9:0]);
    oe = (ones < 4) || (ones > 6);
    if (m_st == 0) begin
      if (cm) begin
        m_emit(m_w, 1, 0);
        m_align = m_n; m_cc = 1; m_err = 0; m_good = 0; m_pend = 0;
        m_st = (LOCK_COMMAS <= 1) ? 2 : 1;
      end
    end else if ((m_n - m_align) % 10 != 0) begin
      if (m_st == 2 && cm) m_pend = 1;
    end else if (m_st == 1) begin
      m_emit(m_w, cm, oe);
      if (oe) begin m_st = 0; m_cc = 0; end
      else if (cm) begin
        m_cc++;
        if (m_cc >= LOCK_COMMAS) begin m_st = 2; m_err = 0; m_good = 0; m_pend = 0; end
      end
    end else begin
      err = oe | m_pend;
      m_pend = 0;
      m_emit(m_w, cm, err);
      if (err) begin
        m_good = 0; m_err++;
        if (m_err >= LOSS_ERRS) begin m_st = 0; m_err = 0; m_cc = 0; end
      end else begin
        m_good++;
        if (m_good >= GOOD_RUN) begin m_good = 0; if (m_err > 0) m_err--; end
      end
    end
  endfunction

  // ---------------- bit source / cycle driver ---------------------------------
  bit q[$];
  bit en_cmd, prev_en, prev_vld, prev_bit, last_ren;
  int rand_pct = 0;
  int cyc = 0;

  typedef struct { logic [9:0] sym; bit comma; bit err; int cnt; int st; bit lk; int cyc; } stb_t;
  stb_t slog[$];
  stb_t pend;
  bit have_pend = 0;

  task automatic push_sym(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic push_bits(input logic [9:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) q.push_back(v[i]);
  endtask

  task automatic cycle();
    bit cur_vld, emp, ren;
    @(posedge clk); #1;
    cyc++;
    e_vld = 0;
    if (!prev_en) m_clear();
    else if (prev_vld) m_bit(prev_bit);
    chk("sym_valid", o_Sym_Valid, e_vld);
    if (e_vld) begin
      chk("sym", o_Sym, e_sym);
      chk("is_comma", o_Is_Comma, e_comma);
      chk("code_err", o_Code_Err, e_err);
    end
    chk("state", o_State, m_st);
    chk("err_cnt", o_Err_Cnt, m_err);
    chk("locked", o_Locked, m_st == 2);
    if (have_pend) begin
      pend.cnt = o_Err_Cnt; pend.st = o_State; pend.lk = o_Locked;
      slog.push_back(pend); have_pend = 0;
    end
    if (o_Sym_Valid) begin
      pend.sym = o_Sym; pend.comma = o_Is_Comma; pend.err = o_Code_Err; pend.cyc = cyc;
      have_pend = 1;
    end
    cur_vld = last_ren;
    if (cur_vld) i_FIFO_Out = q.pop_front();
    emp = (q.size() == 0) || (rand_pct > 0 && ($urandom % 100) < rand_pct);
    i_empty = emp;
    i_Enable = en_cmd;
    ren = en_cmd & ~emp;
    #1;
    chk("r_en", o_R_en, ren);
    prev_vld = cur_vld; prev_bit = i_FIFO_Out; prev_en = en_cmd; last_ren = ren;
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() > 0 || last_ren || prev_vld) && g < 5000) begin cycle(); g++; end
    chk("drain_bound", g < 5000, 1);
    cycle(); cycle();
  endtask

  // ---------------- expected strobe table --------------------------------------
  typedef struct { logic [9:0] sym; bit comma; bit err; int cnt; int st; } vec_t;
  vec_t tbl[$];
  function automatic void add(logic [9:0] s, bit c, bit e, int cnt, int st);
    vec_t v; v.sym = s; v.comma = c; v.err = e; v.cnt = cnt; v.st = st; tbl.push_back(v);
  endfunction

  function automatic logic [9:0] rnd_good();
    logic [9:0] v;
    do v = 10'($urandom); while ($countones(v) < 4 || $countones(v) > 6);
    return v;
  endfunction

  initial begin
    int base, g;
    logic [9:0] held;
    clk = 0; rst_n = 0; i_Enable = 0; i_empty = 1; i_FIFO_Out = 0;
    en_cmd = 0; prev_en = 0; prev_vld = 0; last_ren = 0;
    m_clear();
    #12;
    chk("rst_sym_valid", o_Sym_Valid, 0);
    chk("rst_state", o_State, 0);
    chk("rst_locked", o_Locked, 0);
    chk("rst_err_cnt", o_Err_Cnt, 0);
    chk("rst_sym", o_Sym, 0);
    chk("rst_r_en", o_R_en, 0);
    #10 rst_n = 1;

    // lock, loss on 4 errors, relock, error recovery over a good run
    add(10'h0FA,1,0,0,1); add(10'h2A5,0,0,0,1); add(10'h305,1,0,0,1);
    add(10'h2A5,0,0,0,1); add(10'h0FA,1,0,0,2);
    add(10'h3FF,0,1,1,2); add(10'h2A5,0,0,1,2); add(10'h3FF,0,1,2,2);
    add(10'h2A5,0,0,2,2); add(10'h3FF,0,1,3,2); add(10'h2A5,0,0,3,2);
    add(10'h3FF,0,1,0,0);
    add(10'h0FA,1,0,0,1); add(10'h2A5,0,0,0,1); add(10'h305,1,0,0,1);
    add(10'h2A5,0,0,0,1); add(10'h0FA,1,0,0,2);
    add(10'h3FF,0,1,1,2);
    for (int i = 0; i < 15; i++) add(10'h2A5,0,0,1,2);
    add(10'h2A5,0,0,0,2);

    en_cmd = 1;
    q.push_back(1); q.push_back(0); q.push_back(1);
    foreach (tbl[i]) push_sym(tbl[i].sym);
    drain();
    chk("tbl_count", slog.size(), tbl.size());
    for (int i = 0; i < tbl.size() && i < slog.size(); i++) begin
      chk($sformatf("tbl%0d_sym", i), slog[i].sym, tbl[i].sym);
      chk($sformatf("tbl%0d_comma", i), slog[i].comma, tbl[i].comma);
      chk($sformatf("tbl%0d_err", i), slog[i].err, tbl[i].err);
      chk($sformatf("tbl%0d_cnt", i), slog[i].cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_state", i), slog[i].st, tbl[i].st);
      chk($sformatf("tbl%0d_locked", i), slog[i].lk, tbl[i].st == 2);
    end
    for (int i = 1; i < 5 && i < slog.size(); i++)
      chk("strobe_spacing", slog[i].cyc - slog[i-1].cyc, 10);

    // async reset while locked with a non-zero error count
    push_sym(10'h3FF); push_sym(10'h2A5); push_sym(10'h2A5);
    drain();
    chk("pre_rst_locked", o_Locked, 1);
    chk("pre_rst_err_cnt", o_Err_Cnt, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst_locked", o_Locked, 0);
    chk("midrst_state", o_State, 0);
    chk("midrst_sym_valid", o_Sym_Valid, 0);
    chk("midrst_err_cnt", o_Err_Cnt, 0);
    en_cmd = 0; i_Enable = 0; q.delete(); m_clear();
    prev_en = 0; prev_vld = 0; last_ren = 0; have_pend = 0;
    @(posedge clk); @(posedge clk); #3 rst_n = 1;

    // FIFO empty for 7 cycles in the middle of a locked symbol
    en_cmd = 1;
    push_sym(10'h0FA); push_sym(10'h2A5); push_sym(10'h305); push_sym(10'h2A5); push_sym(10'h0FA);
    push_bits(10'h2A5, 9, 5);
    drain();
    chk("stall_pre_locked", o_Locked, 1);
    base = slog.size();
    held = o_Sym;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("stall_r_en", o_R_en, 0);
      chk("stall_no_strobe", o_Sym_Valid, 0);
      chk("stall_sym_hold", o_Sym, held);
    end
    chk("stall_strobes", slog.size() - base, 0);
    push_bits(10'h2A5, 4, 0);
    drain();
    chk("stall_resume_count", slog.size() - base, 1);
    if (slog.size() > base) begin
      chk("stall_resume_sym", slog[base].sym, 10'h2A5);
      chk("stall_resume_err", slog[base].err, 0);
      chk("stall_resume_lock", slog[base].lk, 1);
    end

    // one-cycle enable drop at bit 5 of a locked symbol
    push_bits(10'h2A5, 9, 5);
    drain();
    chk("drop_pre_locked", o_Locked, 1);
    base = slog.size();
    en_cmd = 0; cycle();
    chk("drop_r_en", o_R_en, 0);
    en_cmd = 1; cycle();
    chk("drop_state", o_State, 0);
    chk("drop_locked", o_Locked, 0);
    push_bits(10'h2A5, 4, 0); push_sym(10'h2A5); push_sym(10'h2A5);
    drain();
    chk("drop_no_strobe", slog.size() - base, 0);

    // randomized traffic with stalls, misalignment and enable drops
    for (int i = 0; i < 300; i++) begin
      int r = $urandom % 20;
      if (r < 5) push_sym(($urandom % 2) ? 10'h0FA : 10'h305);
      else if (r < 15) push_sym(rnd_good());
      else if (r < 17) push_sym(10'($urandom));
      else if (r < 18) push_sym(($urandom % 2) ? 10'h3FF : 10'h000);
      else if (r < 19) for (int k = 0; k < 1 + $urandom % 3; k++) q.push_back(1'($urandom));
      else push_sym(10'h2A5);
    end
    rand_pct = 20;
    g = 0;
    while (q.size() > 0 && g < 30000) begin
      en_cmd = ($urandom % 300) != 0;
      cycle();
      g++;
    end
    chk("random_bound", g < 30000, 1);
    en_cmd = 1; rand_pct = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
